// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush sequencer for load-use hazards, multi-cycle vector memory ops and taken branches,
// with a saturating stall-cycle counter.
module pipeline_controller #(
    parameter int         MEM_LATENCY = 4,
    parameter logic [4:0] OP_LDR      = 5'd3,
    parameter logic [4:0] OP_VLDR     = 5'd16,
    parameter logic [4:0] OP_VSTR     = 5'd17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  d_src1,
    input  logic [3:0]  d_src2,
    input  logic        d_src1_valid,
    input  logic        d_src2_valid,
    input  logic        ex_valid,
    input  logic [4:0]  ex_opcode,
    input  logic [2:0]  ex_wb_register,
    input  logic        branch_taken,
    output logic        en_fetch,
    output logic        en_decode,
    output logic        en_execute,
    output logic        flush_fd,
    output logic        flush_de,
    output logic        bubble_em,
    output logic        busy,
    output logic [15:0] stall_count
);
    localparam int CW = $clog2(MEM_LATENCY);
    typedef enum logic {RUN, VMEM_BUSY} state_t;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_stall;
    logic          w_vmem, w_ld, w_hit, w_hold, w_br, w_lu;
    logic [3:0]    w_tag;
    assign w_vmem = ex_valid & (ex_opcode == OP_VLDR | ex_opcode == OP_VSTR);
    assign w_ld   = ex_valid & (ex_opcode == OP_LDR | ex_opcode == OP_VLDR);
    // A scalar load targets file 0, a vector load file 1.
    assign w_tag  = {ex_opcode == OP_VLDR, ex_wb_register};
    assign w_hit  = w_ld & ((d_src1_valid & d_src1 == w_tag) | (d_src2_valid & d_src2 == w_tag));
    assign w_hold = (r_state == RUN) ? w_vmem : (r_cnt != '0);
    assign w_br   = (r_state == RUN) & ~w_vmem & branch_taken;
    assign w_lu   = ~w_hold & ~w_br & w_hit;
    assign en_fetch    = ~reset & ~w_hold & ~w_lu;
    assign en_decode   = ~reset & ~w_hold & ~w_lu;
    assign en_execute  = ~reset & ~w_hold;
    assign flush_fd    = reset | w_br;
    assign flush_de    = reset | w_br | w_lu;
    assign bubble_em   = reset | w_hold;
    assign busy        = (r_state == VMEM_BUSY);
    assign stall_count = r_stall;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_stall <= '0;
        end else begin
            if (r_state == RUN && w_vmem) begin
                r_state <= VMEM_BUSY;
                r_cnt   <= CW'(MEM_LATENCY - 2);
            end else if (r_state == VMEM_BUSY) begin
                r_state <= (r_cnt == '0) ? RUN : VMEM_BUSY;
                r_cnt   <= (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
            end
            if (!en_decode && r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;
        end
    end
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed vectors for pipeline_controller with hand-computed expectations.
// ctl vector packs {en_fetch, en_decode, en_execute, flush_fd, flush_de, bubble_em, busy}.
module tb_pipeline_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  d_src1 = '0, d_src2 = '0;
    logic        d_src1_valid = 1'b0, d_src2_valid = 1'b0;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_opcode = '0;
    logic [2:0]  ex_wb_register = '0;
    logic        branch_taken = 1'b0;
    logic        en_fetch, en_decode, en_execute, flush_fd, flush_de, bubble_em, busy;
    logic [15:0] stall_count;
    int          n_vec = 0, n_err = 0;

    pipeline_controller dut (
        .clk(clk), .reset(reset),
        .d_src1(d_src1), .d_src2(d_src2),
        .d_src1_valid(d_src1_valid), .d_src2_valid(d_src2_valid),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_wb_register(ex_wb_register),
        .branch_taken(branch_taken),
        .en_fetch(en_fetch), .en_decode(en_decode), .en_execute(en_execute),
        .flush_fd(flush_fd), .flush_de(flush_de), .bubble_em(bubble_em),
        .busy(busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ctl();
        return {9'd0, en_fetch, en_decode, en_execute, flush_fd, flush_de, bubble_em, busy};
    endfunction

    initial begin
        tick();
        #1 check("rst0", ctl(), 16'b0001110);
        tick();
        #1 check("rst1", ctl(), 16'b0001110);
        reset = 1'b0;
        #1 check("run", ctl(), 16'b1110000);
        check("sc0", stall_count, 16'd0);
        ex_valid = 1'b1; ex_opcode = 5'd3; ex_wb_register = 3'd3;
        d_src1 = 4'b0011; d_src1_valid = 1'b1;
        #1 check("lu_hit", ctl(), 16'b0010100);
        tick();
        d_src1 = 4'b1011;
        #1 check("lu_miss", ctl(), 16'b1110000);
        check("sc_lu", stall_count, 16'd1);
        tick();
        ex_opcode = 5'd17; d_src1_valid = 1'b0;
        #1 check("vstr_t0", ctl(), 16'b0000010);
        tick();
        #1 check("vstr_t1", ctl(), 16'b0000011);
        tick();
        #1 check("vstr_t2", ctl(), 16'b0000011);
        tick();
        #1 check("vstr_t3", ctl(), 16'b1110001);
        check("sc_vstr", stall_count, 16'd4);
        tick();
        ex_valid = 1'b0;
        #1 check("vstr_t4", ctl(), 16'b1110000);
        ex_valid = 1'b1; ex_opcode = 5'd16; ex_wb_register = 3'd5;
        d_src2 = 4'b1101; d_src2_valid = 1'b1;
        #1 check("vldr_t0", ctl(), 16'b0000010);
        tick();
        #1 check("vldr_t1", ctl(), 16'b0000011);
        tick();
        #1 check("vldr_t2", ctl(), 16'b0000011);
        tick();
        #1 check("vldr_rel", ctl(), 16'b0010101);
        tick();
        ex_valid = 1'b0;
        #1 check("vldr_t4", ctl(), 16'b1110000);
        check("sc_vldr", stall_count, 16'd8);
        ex_valid = 1'b1; ex_opcode = 5'd1; ex_wb_register = 3'd0;
        d_src2_valid = 1'b0; branch_taken = 1'b1;
        #1 check("br", ctl(), 16'b1111100);
        tick();
        branch_taken = 1'b0;
        #1 check("br_end", ctl(), 16'b1110000);
        check("sc_br", stall_count, 16'd8);
        ex_opcode = 5'd17; branch_taken = 1'b1;
        #1 check("br_vstr", ctl(), 16'b0000010);
        tick();
        #1 check("br_vstr_t1", ctl(), 16'b0000011);
        reset = 1'b1;
        #1 check("rst_busy", ctl(), 16'b0001111);
        tick();
        reset = 1'b0; ex_valid = 1'b0; branch_taken = 1'b0;
        #1 check("rst_run", ctl(), 16'b1110000);
        check("sc_rst", stall_count, 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
